uart_alu_interface: RTL and testbench

- Sits directly downstream of the UART receiver and consumes its rx_done_tick/dout byte stream.
- Assembles a three-byte command frame (operand A, operand B, opcode) and drives the ALU operand and opcode registers.
- Captures the ALU result and hands it to the UART transmitter with a start/done handshake.
- Aborts partial frames on an inter-byte timeout, so a lost byte cannot desynchronise the link permanently.

---
 rtl/uart_alu_interface_pkg.sv | 18 +
 rtl/uart_alu_interface_if.sv | 33 +++
 rtl/uart_alu_interface_frame_timeout_counter.sv | 38 +++
 rtl/uart_alu_interface.sv | 124 ++++++++++++
 tb/tb_uart_alu_interface.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART-to-ALU command bridge: state encoding
// and default widths/timeout.
package uart_pkg;

  localparam int DBIT_DEF         = 8;
  localparam int NB_OP_DEF        = 6;
  localparam int TIMEOUT_CLKS_DEF = 50_000_000;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Bundle of receiver, ALU and transmitter signals seen by the bridge.
// The slave view belongs to the bridge; the master view to its environment.
interface uart_alu_if
  import uart_pkg::*;
#(
  parameter int DBIT  = DBIT_DEF,
  parameter int NB_OP = NB_OP_DEF
) ();

  logic             rx_done_tick;
  logic [DBIT-1:0]  rx_data;
  logic [DBIT-1:0]  alu_result;
  logic             tx_done_tick;
  logic [DBIT-1:0]  alu_a;
  logic [DBIT-1:0]  alu_b;
  logic [NB_OP-1:0] alu_op;
  logic             tx_start;
  logic [DBIT-1:0]  tx_data;
  logic             busy;
  logic             frame_err;
  logic             rx_overrun;

  modport slave (
    input  rx_done_tick, rx_data, alu_result, tx_done_tick,
    output alu_a, alu_b, alu_op, tx_start, tx_data, busy, frame_err, rx_overrun
  );

  modport master (
    output rx_done_tick, rx_data, alu_result, tx_done_tick,
    input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, frame_err, rx_overrun
  );

endinterface

// File: rtl/uart_alu_interface_frame_timeout_counter.sv
// Inter-byte watchdog: counts while enabled, pulses terminal when the last
// allowed clock is reached, and returns to zero on clear, disable or expiry.
module frame_timeout_counter
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int                CNT_W = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign terminal = enable && (count_q == LAST);

  // Clearing on expiry is what keeps the counter from ever wrapping.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || !enable || terminal) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Assembles A/B/opcode frames from the UART receiver, drives the ALU and
// forwards its result to the UART transmitter.
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int DBIT         = DBIT_DEF,
  parameter int NB_OP        = NB_OP_DEF,
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input logic      clk,
  input logic      reset,
  uart_alu_if.slave bus
);

  state_t           state_q, state_d;
  logic [DBIT-1:0]  alu_a_q, alu_a_d;
  logic [DBIT-1:0]  alu_b_q, alu_b_d;
  logic [NB_OP-1:0] alu_op_q, alu_op_d;
  logic [DBIT-1:0]  tx_data_q, tx_data_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             cnt_clear, cnt_enable, cnt_terminal;

  assign cnt_enable = (state_q == WAIT_B) || (state_q == WAIT_OP);

  frame_timeout_counter #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // A byte arriving on the expiry cycle takes priority over the abort.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tx_data_d    = tx_data_q;
    frame_err_d  = 1'b0;
    rx_overrun_d = 1'b0;
    cnt_clear    = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (bus.rx_done_tick) begin
          alu_a_d   = bus.rx_data;
          cnt_clear = 1'b1;
          state_d   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.rx_done_tick) begin
          alu_b_d   = bus.rx_data;
          cnt_clear = 1'b1;
          state_d   = WAIT_OP;
        end else if (cnt_terminal) begin
          frame_err_d = 1'b1;
          state_d     = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (bus.rx_done_tick) begin
          alu_op_d  = bus.rx_data[NB_OP-1:0];
          cnt_clear = 1'b1;
          state_d   = EXEC;
        end else if (cnt_terminal) begin
          frame_err_d = 1'b1;
          state_d     = WAIT_A;
        end
      end
      EXEC: begin
        tx_data_d    = bus.alu_result;
        rx_overrun_d = bus.rx_done_tick;
        state_d      = SEND;
      end
      SEND: begin
        rx_overrun_d = bus.rx_done_tick;
        state_d      = WAIT_TX;
      end
      WAIT_TX: begin
        rx_overrun_d = bus.rx_done_tick;
        if (bus.tx_done_tick) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= WAIT_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tx_data_q    <= '0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tx_data_q    <= tx_data_d;
      frame_err_q  <= frame_err_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = (state_q == SEND);
  assign bus.busy       = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: directed frames plus randomized traffic,
// every cycle compared with a frame-level reference model.
module tb_uart_alu_interface;

  localparam int T = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;

  uart_alu_if #(.DBIT(8), .NB_OP(6)) bus ();

  uart_alu_interface #(
    .DBIT(8), .NB_OP(6), .TIMEOUT_CLKS(T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // The ALU is modelled as an 8-bit adder.
  assign bus.alu_result = bus.alu_a + bus.alu_b;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes collected so far in the frame, idle clocks since
  // the last accepted byte, and clocks elapsed since the opcode arrived.
  int       m_nbytes = 0;
  int       m_idle = 0;
  int       m_since_op = -1;
  bit [7:0] m_a = 0, m_b = 0, m_tx = 0;
  bit [5:0] m_op = 0;
  bit       m_ferr = 0, m_ovr = 0;

  task automatic modelStep(input bit rst_n, input bit rx, input bit [7:0] rxd, input bit txd);
    if (!rst_n) begin
      m_nbytes = 0; m_idle = 0; m_since_op = -1;
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_ferr = 0; m_ovr = 0;
      return;
    end
    m_ferr = 0;
    m_ovr  = 0;
    if (m_since_op >= 0) begin
      if (rx) m_ovr = 1;
      if (m_since_op == 0) begin
        m_tx = m_a + m_b;
        m_since_op = 1;
      end else if (m_since_op == 1) begin
        m_since_op = 2;
      end else if (txd) begin
        m_since_op = -1;
      end
    end else if (rx) begin
      m_idle = 0;
      if (m_nbytes == 0) begin
        m_a = rxd; m_nbytes = 1;
      end else if (m_nbytes == 1) begin
        m_b = rxd; m_nbytes = 2;
      end else begin
        m_op = rxd[5:0]; m_nbytes = 0; m_since_op = 0;
      end
    end else if (m_nbytes > 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_ferr = 1; m_nbytes = 0; m_idle = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(reset, bus.rx_done_tick, bus.rx_data, bus.tx_done_tick);
    #1;
    checkOutput("alu_a",      bus.alu_a,      m_a);
    checkOutput("alu_b",      bus.alu_b,      m_b);
    checkOutput("alu_op",     bus.alu_op,     m_op);
    checkOutput("tx_data",    bus.tx_data,    m_tx);
    checkOutput("busy",       bus.busy,       m_since_op >= 0);
    checkOutput("tx_start",   bus.tx_start,   m_since_op == 1);
    checkOutput("frame_err",  bus.frame_err,  m_ferr);
    checkOutput("rx_overrun", bus.rx_overrun, m_ovr);
    if (bus.frame_err === 1'b1) ferr_seen++;
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int gap);
    repeat (gap) cycle();
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = d;
    cycle();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic txDone(input int delay);
    repeat (delay) cycle();
    bus.tx_done_tick = 1'b1;
    cycle();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic waitTxStart();
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    checkOutput("tx_start_seen", bus.tx_start, 1);
  endtask

  initial begin
    int f0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.tx_done_tick = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_alu_a", bus.alu_a, 0);

    $display("[TB] nominal frame");
    applyStimulus(8'h12, 10);
    applyStimulus(8'h34, 10);
    applyStimulus(8'h20, 10);
    checkOutput("nom_alu_a", bus.alu_a, 8'h12);
    checkOutput("nom_alu_b", bus.alu_b, 8'h34);
    checkOutput("nom_alu_op", bus.alu_op, 6'h20);
    checkOutput("nom_no_start_yet", bus.tx_start, 0);
    cycle();
    checkOutput("nom_tx_start", bus.tx_start, 1);
    checkOutput("nom_tx_data", bus.tx_data, 8'h46);
    txDone(5);
    checkOutput("nom_idle", bus.busy, 0);

    $display("[TB] timeout");
    f0 = ferr_seen;
    applyStimulus(8'hAA, 3);
    repeat (T) cycle();
    checkOutput("to_pulses", ferr_seen - f0, 1);
    applyStimulus(8'h01, 2);
    applyStimulus(8'h02, 2);
    applyStimulus(8'h00, 2);
    checkOutput("to_fresh_a", bus.alu_a, 8'h01);
    waitTxStart();
    checkOutput("to_fresh_tx", bus.tx_data, 8'h03);
    txDone(3);

    $display("[TB] overrun");
    applyStimulus(8'h05, 2);
    applyStimulus(8'h06, 2);
    applyStimulus(8'h07, 2);
    applyStimulus(8'hFF, 2);
    checkOutput("ovr_pulse", bus.rx_overrun, 1);
    checkOutput("ovr_alu_a", bus.alu_a, 8'h05);
    checkOutput("ovr_tx_data", bus.tx_data, 8'h0B);
    txDone(2);
    applyStimulus(8'h10, 2);
    applyStimulus(8'h20, 2);
    applyStimulus(8'hE5, 2);
    checkOutput("mask_alu_op", bus.alu_op, 6'h25);
    waitTxStart();
    checkOutput("mask_tx_data", bus.tx_data, 8'h30);
    txDone(1);

    $display("[TB] reset mid-operation");
    applyStimulus(8'h55, 2);
    applyStimulus(8'h66, 2);
    reset = 1'b0; cycle(); reset = 1'b1;
    checkOutput("rst_op_alu_b", bus.alu_b, 0);
    checkOutput("rst_op_busy", bus.busy, 0);
    applyStimulus(8'h01, 2);
    applyStimulus(8'h02, 2);
    applyStimulus(8'h03, 2);
    cycle(); cycle();
    reset = 1'b0; cycle(); reset = 1'b1;
    checkOutput("rst_tx_data", bus.tx_data, 0);
    checkOutput("rst_tx_op", bus.alu_op, 0);
    txDone(1);
    cycle();
    checkOutput("rst_stale_busy", bus.busy, 0);

    $display("[TB] expiry race");
    f0 = ferr_seen;
    applyStimulus(8'h33, 2);
    applyStimulus(8'h44, T - 1);
    checkOutput("race_no_abort", ferr_seen - f0, 0);
    checkOutput("race_alu_b", bus.alu_b, 8'h44);
    applyStimulus(8'h01, 2);
    waitTxStart();
    checkOutput("race_tx_data", bus.tx_data, 8'h77);
    txDone(1);

    $display("[TB] random traffic");
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 2500; i++) begin
        bus.rx_done_tick = ($urandom_range(0, 99) < (phase == 0 ? 20 : 5));
        bus.rx_data      = 8'($urandom);
        bus.tx_done_tick = ($urandom_range(0, 99) < 15);
        reset            = ($urandom_range(0, 499) != 0);
        cycle();
      end
    end
    bus.rx_done_tick = 1'b0;
    bus.tx_done_tick = 1'b0;
    reset = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
